// File: rtl/reg_file_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_NRD   = 2;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the register file and its user: reads, writes, issue, clear.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW,
    parameter int NRD   = DEF_NRD
);

    logic                   clr;
    logic                   ready;
    logic [NRD*AW-1:0]      ra;
    logic [NRD*WIDTH-1:0]   rd;
    logic [NRD-1:0]         rd_busy;
    logic                   we0;
    logic [AW-1:0]          wa0;
    logic [WIDTH-1:0]       wd0;
    logic                   we1;
    logic [AW-1:0]          wa1;
    logic [WIDTH-1:0]       wd1;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [AW-1:0]          ra_dbu;
    logic [WIDTH-1:0]       rd_dbu;

    modport master (
        output clr, ra, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr, ra_dbu,
        input  ready, rd, rd_busy, rd_dbu
    );

    modport slave (
        input  clr, ra, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr, ra_dbu,
        output ready, rd, rd_busy, rd_dbu
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port with write-first bypass and scoreboard lookup.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   word,
    input  logic               we0,
    input  logic [AW-1:0]      wa0,
    input  logic [WIDTH-1:0]   wd0,
    input  logic               we1,
    input  logic [AW-1:0]      wa1,
    input  logic [WIDTH-1:0]   wd1,
    input  logic [2**AW-1:0]   busy,
    input  logic               ready,
    output logic [WIDTH-1:0]   data,
    output logic               busy_out
);

    // Write enables arrive already qualified, so a match means the write really lands.
    always_comb begin
        data     = '0;
        busy_out = 1'b0;
        if (ready && addr != '0) begin
            busy_out = busy[addr];
            if (we1 && wa1 == addr)
                data = wd1;
            else if (we0 && wa0 == addr)
                data = wd0;
            else
                data = word;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with busy scoreboard and a sequential clear sweep.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW,
    parameter int NRD   = DEF_NRD
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_mp_if.slave bus
);

    localparam int DEPTH = 2**AW;

    state_t             state;
    logic [AW-1:0]      cnt;
    logic               ready_q;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]   busy;

    logic               w0_ok;
    logic               w1_ok;
    logic               iss_ok;
    logic [WIDTH-1:0]   rd_arr   [NRD];
    logic               busy_arr [NRD];
    logic               dbu_busy_unused;

    assign w0_ok    = bus.we0 && ready_q && bus.wa0 != '0;
    assign w1_ok    = bus.we1 && ready_q && bus.wa1 != '0;
    assign iss_ok   = bus.iss_en && ready_q && bus.iss_addr != '0;
    assign bus.ready = ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (w0_ok) mem[bus.wa0] <= bus.wd0;
            if (w1_ok) mem[bus.wa1] <= bus.wd1;
        end
    end

    // Issue is applied last so it overrides a same-cycle write clearing the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (state == CLEAR) begin
            busy[cnt] <= 1'b0;
        end else begin
            if (w0_ok)  busy[bus.wa0]      <= 1'b0;
            if (w1_ok)  busy[bus.wa1]      <= 1'b0;
            if (iss_ok) busy[bus.iss_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rf_read_port #(.WIDTH(WIDTH), .AW(AW)) u_port (
            .addr     (bus.ra[i*AW +: AW]),
            .word     (mem[bus.ra[i*AW +: AW]]),
            .we0      (w0_ok),
            .wa0      (bus.wa0),
            .wd0      (bus.wd0),
            .we1      (w1_ok),
            .wa1      (bus.wa1),
            .wd1      (bus.wd1),
            .busy     (busy),
            .ready    (ready_q),
            .data     (rd_arr[i]),
            .busy_out (busy_arr[i])
        );
    end

    rf_read_port #(.WIDTH(WIDTH), .AW(AW)) u_dbu (
        .addr     (bus.ra_dbu),
        .word     (mem[bus.ra_dbu]),
        .we0      (w0_ok),
        .wa0      (bus.wa0),
        .wd0      (bus.wd0),
        .we1      (w1_ok),
        .wa1      (bus.wa1),
        .wd1      (bus.wd1),
        .busy     (busy),
        .ready    (ready_q),
        .data     (bus.rd_dbu),
        .busy_out (dbu_busy_unused)
    );

    always_comb begin
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd[i*WIDTH +: WIDTH] = rd_arr[i];
            bus.rd_busy[i]           = busy_arr[i];
        end
    end

endmodule
